// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state type, parity modes and parity helper.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;
   localparam int PAR_NONE = 0;
   localparam int PAR_ODD = 1;
   localparam int PAR_EVEN = 2;
   localparam int MAX_DATA_BITS = 9;
   function automatic logic parity(input logic [MAX_DATA_BITS-1:0] d);
      return ^d;
   endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter producing center-1, center and center+1 strobes.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   input  logic enable,
   output logic mid_early,
   output logic mid,
   output logic mid_late
);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int W = $clog2(CLKS_PER_BIT + 1);
   logic [W-1:0] cnt;
   // cnt holds the number of cycles since restart, wrapping 1..CLKS_PER_BIT
   always_ff @(posedge clk)
      if (!reset_n || restart) cnt <= W'(1);
      else if (enable) cnt <= (cnt == W'(CLKS_PER_BIT)) ? W'(1) : cnt + W'(1);
   assign mid_early = enable && cnt == W'(HALF - 1);
   assign mid = enable && cnt == W'(HALF);
   assign mid_late = enable && cnt == W'(HALF + 1);
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with majority voting, error flags and valid/ready output.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 pskClk,
   input  logic                 resetN,
   input  logic                 rxInput,
   input  logic                 rxReady,
   output logic [DATA_BITS-1:0] rxData,
   output logic                 rxValid,
   output logic                 rxParityErr,
   output logic                 rxFrameErr,
   output logic                 rxOverrun,
   output logic                 rxBusy,
   output logic                 rxLEDFlag
);
   state_t state;
   logic s_meta, s, s_d, v0, v1, vote, fall, fe_next, par_x, last_stop, load;
   logic mid_early, mid, mid_late;
   logic [3:0] bit_cnt;
   logic stop_cnt, par_err, frm_err;
   logic [DATA_BITS-1:0] shreg;
   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) timer (
      .clk(pskClk),
      .reset_n(resetN),
      .restart(fall && state == IDLE),
      .enable(state != IDLE),
      .mid_early(mid_early),
      .mid(mid),
      .mid_late(mid_late)
   );
   assign fall = s_d && !s;
   assign vote = (v0 && v1) || (v0 && s) || (v1 && s);
   assign fe_next = frm_err || !vote;
   assign par_x = parity(MAX_DATA_BITS'(shreg)) ^ vote;
   assign last_stop = state == STOP && mid_late && stop_cnt == 1'(STOP_BITS - 1);
   assign load = last_stop && (!rxValid || rxReady);
   assign rxBusy = state != IDLE;
   always_ff @(posedge pskClk)
      if (!resetN) begin
         s_meta <= 1'b1;
         s <= 1'b1;
         s_d <= 1'b1;
         v0 <= 1'b1;
         v1 <= 1'b1;
         state <= IDLE;
         bit_cnt <= '0;
         stop_cnt <= 1'b0;
         shreg <= '0;
         par_err <= 1'b0;
         frm_err <= 1'b0;
      end else begin
         s_meta <= rxInput;
         s <= s_meta;
         s_d <= s;
         if (mid_early) v0 <= s;
         if (mid) v1 <= s;
         case (state)
            IDLE: if (fall) begin
               state <= START;
               bit_cnt <= '0;
               stop_cnt <= 1'b0;
               par_err <= 1'b0;
               frm_err <= 1'b0;
            end
            START: if (mid_late) state <= vote ? IDLE : DATA;
            DATA: if (mid_late) begin
               shreg <= {vote, shreg[DATA_BITS-1:1]};
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'(DATA_BITS - 1)) state <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            end
            PARITY: if (mid_late) begin
               par_err <= (PARITY_MODE == PAR_ODD) ? !par_x : par_x;
               state <= STOP;
            end
            STOP: if (mid_late) begin
               frm_err <= fe_next;
               stop_cnt <= stop_cnt + 1'b1;
               // an all-zero word with a low stop bit is a break: hold off until the line recovers
               if (last_stop) state <= (fe_next && shreg == '0) ? BREAK_WAIT : IDLE;
            end
            BREAK_WAIT: if (s) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   always_ff @(posedge pskClk)
      if (!resetN) begin
         rxData <= '0;
         rxValid <= 1'b0;
         rxParityErr <= 1'b0;
         rxFrameErr <= 1'b0;
         rxOverrun <= 1'b0;
         rxLEDFlag <= 1'b0;
      end else begin
         rxOverrun <= last_stop && !load;
         if (load) begin
            rxData <= shreg;
            rxValid <= 1'b1;
            rxParityErr <= par_err;
            rxFrameErr <= fe_next;
            rxLEDFlag <= !rxLEDFlag;
         end else if (rxReady) rxValid <= 1'b0;
      end
endmodule
